// File: rtl/bist_chain_scheduler.sv
// ============================================================================
// Module      : bist_chain_scheduler
// Description : Walks the BIST across enabled scan chains: select, reset,
//               clock PAT_LEN prescaled test clocks, sample the comparator.
//               Optional macro BIST_LOOP_EN makes the run wrap continuously.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bist_chain_scheduler #(
    parameter int CHAINS  = 6,
    parameter int PAT_LEN = 32,
    parameter int CNT_W   = 14
) (
    input  logic              sys_clock,
    input  logic              sys_reset,
    input  logic              start,
    input  logic              tick,
    input  logic              stop,
    input  logic              continua,
    input  logic              halt_on_err,
    input  logic [CHAINS-1:0] chain_mask,
    input  logic              comparison_result,
    output logic [CHAINS-1:0] K,
    output logic [2:0]        bist_decoder_input,
    output logic              mode_mux_sel,
    output logic              clock_mux_sel,
    output logic              test_clk_en,
    output logic              test_reset,
    output logic              error_flag,
    output logic [CNT_W-1:0]  err_count,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SHIFT  = 3'd2,
        S_CHECK1 = 3'd3,
        S_CHECK2 = 3'd4,
        S_HALT   = 3'd5,
        S_NEXT   = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    localparam logic [7:0] c_last_bit = 8'(PAT_LEN - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_idx;
    logic [2:0]       w_idx_nxt;
    logic [7:0]       r_bit_cnt;
    logic             r_clk_en;
    logic             r_cont_q;
    logic             r_err_flag;
    logic [CNT_W-1:0] r_err_count;

    logic             w_busy;
    logic             w_any;
    logic [2:0]       w_lowest;
    logic [2:0]       w_higher;
    logic             w_has_higher;
    logic             w_shift_tick;
    logic             w_clr_err;
    logic             w_err_inc;

    assign w_busy       = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_any        = |chain_mask;
    assign w_shift_tick = (r_state == S_SHIFT) && tick && !stop;

    // Lowest enabled chain, and the nearest enabled chain above the current one
    always_comb begin
        w_lowest     = '0;
        w_higher     = '0;
        w_has_higher = 1'b0;
        for (int i = CHAINS - 1; i >= 0; i--) begin
            if (chain_mask[i]) begin
                w_lowest = 3'(i);
                if (3'(i) > r_idx) begin
                    w_higher     = 3'(i);
                    w_has_higher = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sys_clock) begin
        if (sys_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_clr_err   = 1'b0;
        w_err_inc   = 1'b0;
        if (stop && w_busy) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        w_clr_err = 1'b1;
                        if (w_any) begin
                            w_idx_nxt   = w_lowest;
                            w_state_nxt = S_LOAD;
                        end else begin
                            w_state_nxt = S_DONE;
                        end
                    end
                end
                S_LOAD:   w_state_nxt = S_SHIFT;
                S_SHIFT: begin
                    if (tick && (r_bit_cnt == c_last_bit)) begin
                        w_state_nxt = S_CHECK1;
                    end
                end
                S_CHECK1: w_state_nxt = S_CHECK2;
                S_CHECK2: begin
                    if (comparison_result) begin
                        w_err_inc   = 1'b1;
                        w_state_nxt = halt_on_err ? S_HALT : S_NEXT;
                    end else begin
                        w_state_nxt = S_NEXT;
                    end
                end
                S_HALT: begin
                    if (continua && !r_cont_q) begin
                        w_state_nxt = S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (w_has_higher) begin
                        w_idx_nxt   = w_higher;
                        w_state_nxt = S_LOAD;
                    end else begin
`ifdef BIST_LOOP_EN
                        if (w_any) begin
                            w_idx_nxt   = w_lowest;
                            w_state_nxt = S_LOAD;
                        end else begin
                            w_state_nxt = S_DONE;
                        end
`else
                        w_state_nxt = S_DONE;
`endif
                    end
                end
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clock) begin
        if (sys_reset) begin
            r_idx       <= '0;
            r_bit_cnt   <= '0;
            r_clk_en    <= 1'b0;
            r_cont_q    <= 1'b0;
            r_err_flag  <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_idx    <= w_idx_nxt;
            r_cont_q <= continua;
            // Test clock lags the accepted tick by one cycle
            r_clk_en <= w_shift_tick;
            if (r_state == S_LOAD) begin
                r_bit_cnt <= '0;
            end else if (w_shift_tick) begin
                r_bit_cnt <= r_bit_cnt + 8'd1;
            end
            if (w_clr_err) begin
                r_err_flag  <= 1'b0;
                r_err_count <= '0;
            end else if (w_err_inc) begin
                r_err_flag <= 1'b1;
                if (r_err_count != {CNT_W{1'b1}}) begin
                    r_err_count <= r_err_count + 1'b1;
                end
            end
        end
    end

    always_comb begin
        K = '0;
        for (int i = 0; i < CHAINS; i++) begin
            if (w_busy && (r_idx == 3'(i))) begin
                K[i] = 1'b1;
            end
        end
    end

    assign bist_decoder_input = r_idx;
    assign mode_mux_sel       = w_busy;
    assign busy               = w_busy;
    assign done               = (r_state == S_DONE);
    assign clock_mux_sel      = (r_state == S_SHIFT) || (r_state == S_CHECK1) ||
                                (r_state == S_CHECK2);
    assign test_clk_en        = r_clk_en;
    assign test_reset         = (r_state == S_LOAD);
    assign error_flag         = r_err_flag;
    assign err_count          = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_bist_chain_scheduler.sv
// ============================================================================
// Module      : tb_bist_chain_scheduler
// Description : Randomized and directed bench for bist_chain_scheduler with a
//               chain-level scoreboard; a second instance uses a 2-bit counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bist_chain_scheduler;

    localparam int CHAINS  = 6;
    localparam int PAT_LEN = 4;
    localparam int BOUND   = 3000;

    logic              clk = 1'b0;
    logic              rst;
    logic              start, tick, stop, continua, halt_on_err;
    logic [CHAINS-1:0] chain_mask;
    logic [CHAINS-1:0] fail_vec;
    logic              cmp;

    logic [CHAINS-1:0] k, s_k;
    logic [2:0]        dec, s_dec;
    logic              mode_sel, clk_sel, clk_en, trst, eflag, bsy, dn;
    logic              s_mode_sel, s_clk_sel, s_clk_en, s_trst, s_eflag, s_bsy, s_dn;
    logic [13:0]       ecnt;
    logic [1:0]        s_ecnt;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    // Comparator stand-in: the selected chain mismatches if flagged in fail_vec
    assign cmp = |(k & fail_vec);

    bist_chain_scheduler #(.CHAINS(CHAINS), .PAT_LEN(PAT_LEN), .CNT_W(14)) dut (
        .sys_clock(clk), .sys_reset(rst), .start(start), .tick(tick), .stop(stop),
        .continua(continua), .halt_on_err(halt_on_err), .chain_mask(chain_mask),
        .comparison_result(cmp), .K(k), .bist_decoder_input(dec),
        .mode_mux_sel(mode_sel), .clock_mux_sel(clk_sel), .test_clk_en(clk_en),
        .test_reset(trst), .error_flag(eflag), .err_count(ecnt), .busy(bsy), .done(dn)
    );

    bist_chain_scheduler #(.CHAINS(CHAINS), .PAT_LEN(PAT_LEN), .CNT_W(2)) dut_sat (
        .sys_clock(clk), .sys_reset(rst), .start(start), .tick(tick), .stop(stop),
        .continua(continua), .halt_on_err(halt_on_err), .chain_mask(chain_mask),
        .comparison_result(cmp), .K(s_k), .bist_decoder_input(s_dec),
        .mode_mux_sel(s_mode_sel), .clock_mux_sel(s_clk_sel), .test_clk_en(s_clk_en),
        .test_reset(s_trst), .error_flag(s_eflag), .err_count(s_ecnt), .busy(s_bsy),
        .done(s_dn)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int k_index(input logic [CHAINS-1:0] v);
        for (int i = 0; i < CHAINS; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int sat(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check_eq("stop_busy", bsy, 0);
        check_eq("stop_k", k, 0);
    endtask

    // Scoreboard run: chains visited in ascending mask order, PAT_LEN clocks
    // each, error count = number of failing visits (saturating per width)
    task automatic run_random(input logic [CHAINS-1:0] mask, input logic [CHAINS-1:0] fails,
                              input int tick_pct);
        int pulses[CHAINS];
        int visits[$];
        int order[$];
        int pop, nfail, passes, nvis;
        bit got, saw_done;
        for (int i = 0; i < CHAINS; i++) begin
            pulses[i] = 0;
            if (mask[i]) order.push_back(i);
        end
        pop   = order.size();
        nfail = $countones(mask & fails);
        passes = 1;
`ifdef BIST_LOOP_EN
        if (pop > 0) passes = 2;
`endif
        nvis = (passes == 2) ? 2 * pop + 1 : pop;
        chain_mask = mask; fail_vec = fails; halt_on_err = 1'b0; continua = 1'b0;
        tick = 1'b1; start = 1'b1;
        got = 1'b0; saw_done = 1'b0;
        for (int c = 0; c < BOUND; c++) begin
            @(negedge clk);
            if (clk_en && k_index(k) >= 0) pulses[k_index(k)]++;
            if (trst) visits.push_back(k_index(k));
            if (dn) saw_done = 1'b1;
            if ((passes == 2) ? (visits.size() == nvis) : dn) begin
                got = 1'b1;
                break;
            end
            start = ($urandom_range(0, 9) == 0);
            tick  = ($urandom_range(1, 100) <= tick_pct);
        end
        start = 1'b0;
        check_eq("run_timeout", got, 1);
        check_eq("visit_cnt", visits.size(), nvis);
        for (int j = 0; j < visits.size() && pop > 0; j++)
            check_eq("visit_chain", visits[j], order[j % pop]);
        for (int i = 0; i < CHAINS; i++)
            check_eq("clk_pulses", pulses[i], mask[i] ? passes * PAT_LEN : 0);
        check_eq("err_count", ecnt, sat(passes * nfail, 14));
        check_eq("err_count_sat", s_ecnt, sat(passes * nfail, 2));
        check_eq("error_flag", eflag, (nfail > 0) ? 1 : 0);
        if (passes == 2) begin
            check_eq("loop_no_done", saw_done, 0);
            pulse_stop();
        end else begin
            check_eq("run_done", dn, 1);
            check_eq("run_idle_k", k, 0);
        end
    endtask

    initial begin
        int p[CHAINS];
        int first_done;
        bit got;

        rst = 1'b1; start = 0; tick = 0; stop = 0; continua = 0; halt_on_err = 0;
        chain_mask = '0; fail_vec = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_k", k, 0);
        check_eq("rst_dec", dec, 0);
        check_eq("rst_busy", bsy, 0);
        check_eq("rst_done", dn, 0);
        check_eq("rst_mode", mode_sel, 0);
        check_eq("rst_clksel", clk_sel, 0);
        check_eq("rst_clk_en", clk_en, 0);
        check_eq("rst_trst", trst, 0);
        check_eq("rst_err", {eflag, 14'(ecnt)}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Cycle-exact timing: mask 000101, tick every cycle
        for (int i = 0; i < CHAINS; i++) p[i] = 0;
        chain_mask = 6'b000101; fail_vec = '0; tick = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("load_trst", trst, 1);
        check_eq("load_k", k, 6'b000001);
        check_eq("load_mode", mode_sel, 1);
        check_eq("load_clksel", clk_sel, 0);
        @(negedge clk);
        check_eq("shift_clksel", clk_sel, 1);
        check_eq("shift_trst", trst, 0);
        check_eq("shift_clk_en", clk_en, 0);
        first_done = -1;
        for (int e = 2; e <= 16; e++) begin
            @(negedge clk);
            if (e == 2) check_eq("first_clk_en", clk_en, 1);
            if (clk_en && k_index(k) >= 0) p[k_index(k)]++;
            if (dn && first_done < 0) first_done = e;
        end
        check_eq("pulses_ch0", p[0], PAT_LEN);
        check_eq("pulses_ch2", p[2], PAT_LEN);
        check_eq("pulses_ch1", p[1], 0);
`ifdef BIST_LOOP_EN
        check_eq("wrap_k", k, 6'b000001);
        check_eq("wrap_trst", trst, 1);
        check_eq("wrap_no_done", first_done, -1);
        pulse_stop();
`else
        check_eq("done_cycle", first_done, 16);
        check_eq("done_mode", mode_sel, 0);
        check_eq("done_err", ecnt, 0);
`endif

        // All chains failing, then five failing chains through a 2-bit counter
        run_random(6'b111111, 6'b111111, 70);
        run_random(6'b111111, 6'b101111, 50);
        run_random(6'b000000, 6'b111111, 100);
        for (int r = 0; r < 6; r++)
            run_random(6'($urandom), 6'($urandom), $urandom_range(30, 100));

        // Halt on chain 2 with continua held high from before
        chain_mask = 6'b111111; fail_vec = 6'b000100; halt_on_err = 1'b1;
        continua = 1'b1; tick = 1'b1; start = 1'b1;
        got = 1'b0;
        for (int c = 0; c < BOUND; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (ecnt == 14'd1) begin
                got = 1'b1;
                break;
            end
        end
        check_eq("halt_reach", got, 1);
        repeat (8) begin
            tick = 1'($urandom);
            @(negedge clk);
        end
        check_eq("halt_k", k, 6'b000100);
        check_eq("halt_busy", bsy, 1);
        check_eq("halt_clk_en", clk_en, 0);
        continua = 1'b0;
        @(negedge clk);
        check_eq("halt_hold_k", k, 6'b000100);
        continua = 1'b1; tick = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("resume_k", k, 6'b001000);
        check_eq("resume_trst", trst, 1);
`ifdef BIST_LOOP_EN
        pulse_stop();
`else
        got = 1'b0;
        for (int c = 0; c < BOUND; c++) begin
            @(negedge clk);
            if (dn) begin
                got = 1'b1;
                break;
            end
        end
        check_eq("halt_run_done", got, 1);
`endif
        check_eq("halt_err", ecnt, 1);
        halt_on_err = 1'b0;

        // Stop mid-SHIFT of chain 3 after one failure
        fail_vec = 6'b000001; tick = 1'b1; start = 1'b1;
        got = 1'b0;
        for (int c = 0; c < BOUND; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 6'b001000 && clk_sel) begin
                got = 1'b1;
                break;
            end
        end
        check_eq("stop_reach", got, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check_eq("stop_idle", bsy, 0);
        check_eq("stop_k0", k, 0);
        check_eq("stop_done", dn, 0);
        check_eq("stop_clk_en", clk_en, 0);
        check_eq("stop_err", ecnt, 1);
        check_eq("stop_flag", eflag, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("restart_err", ecnt, 0);
        check_eq("restart_flag", eflag, 0);
        check_eq("restart_k", k, 6'b000001);

        // Reset mid-run
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("mrst_busy", bsy, 0);
        check_eq("mrst_dec", dec, 0);
        check_eq("mrst_clk_en", clk_en, 0);
        repeat (3) @(negedge clk);
        check_eq("mrst_quiet", {clk_en, trst, bsy}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bist_chain_scheduler.md
# bist_chain_scheduler

Sequencer that runs the built-in self-test across the FPGA's scan chains one at a time. For each enabled chain it selects the chain, resets the logic under test, issues a fixed number of prescaled test clocks, samples the comparator verdict, and accumulates an error count for the seven-segment display path. It sits between the prescaler/switch front end and the chain muxes, decoders and comparator inside `TOP`.

## Interface
- `CHAINS`, 6, number of scan chains; index width is 3 bits, so `CHAINS` ≤ 8.
- `PAT_LEN`, 32, number of test clocks per chain, from 1 to 255.
- `CNT_W`, 14, width of the error counter (up to 9999 fits the display).

Ports:
- `sys_clock` in 1: system clock.
- `sys_reset` in 1: synchronous, active-high reset.
- `start` in 1: level-sampled; starts a run when accepted.
- `tick` in 1: one-cycle enable from the prescaler.
- `stop` in 1: abort the run.
- `continua` in 1: resume from a halt; rising edge is detected internally.
- `halt_on_err` in 1: enter HALT after a failing chain.
- `chain_mask` in `CHAINS`: 1 means the chain is tested.
- `comparison_result` in 1: 1 means mismatch.
- `K` out `CHAINS`: one-hot selected chain; 0 when idle.
- `bist_decoder_input` out 3: index of the current chain.
- `mode_mux_sel` out 1: test mode; 1 in every state except IDLE and DONE.
- `clock_mux_sel` out 1: 1 in SHIFT and CHECK.
- `test_clk_en` out 1: one-cycle test-clock enable.
- `test_reset` out 1: chain reset pulse.
- `error_flag` out 1: sticky failure indicator.
- `err_count` out `CNT_W`: saturating count of failing chains.
- `busy` out 1: state is neither IDLE nor DONE.
- `done` out 1: state is DONE.

## Operation
- States: IDLE, LOAD, SHIFT, CHECK1, CHECK2, HALT, NEXT, DONE.
- Reset:
  - State goes to IDLE.
  - All outputs are 0.
  - `bist_decoder_input`, the bit counter and the `continua` edge register are cleared.
- Start acceptance (IDLE or DONE, `start`=1):
  - `err_count` and `error_flag` clear.
  - The index loads the lowest set bit of `chain_mask`, and the state goes to LOAD.
  - If `chain_mask`=0, the state goes directly to DONE with counters cleared.
  - `start` is ignored in all other states.
- LOAD: lasts 1 cycle; `test_reset`=1, bit counter cleared; then SHIFT.
- SHIFT:
  - Each cycle with `tick`=1 increments the bit counter and asserts `test_clk_en` in the following cycle (registered).
  - The tick that brings the count to `PAT_LEN` moves the state to CHECK1.
- CHECK1: settle cycle in which the final `test_clk_en` pulse is high; then CHECK2.
- CHECK2: samples `comparison_result`.
  - On 1: `error_flag`←1 and `err_count`+1, saturating at all ones. Then HALT if `halt_on_err`=1, otherwise NEXT.
  - On 0: NEXT.
- HALT: holds all selects. A rising edge of `continua` (registered value 0, current value 1) moves the state to NEXT. A `continua` held high from before HALT is entered does not resume.
- NEXT: the index advances to the next higher set bit of `chain_mask`, sampled in this cycle. If one exists, go to LOAD; otherwise go to DONE.
- DONE: `done`=1; holds `error_flag` and `err_count`; leaves only on start acceptance.
- `stop`=1 in any busy state:
  - State goes to IDLE next cycle.
  - `error_flag` and `err_count` are retained; `done` stays 0.
  - `stop` has priority over `tick`, `continua` and the CHECK2 update, but not over `sys_reset`.
- `K` = one-hot of `bist_decoder_input` while busy, otherwise 0.
- `tick` has no effect outside SHIFT.

## Timing
- `start` sampled high in cycle N:
  - LOAD in N+1, with `test_reset` high in N+1.
  - SHIFT in N+2.
- With `tick` every cycle, the first `test_clk_en` is at N+3.
- Per chain with continuous ticks: 1 (LOAD) + `PAT_LEN` (SHIFT) + 2 (CHECK) + 1 (NEXT) = `PAT_LEN`+4 cycles.
- `comparison_result` must be valid 1 cycle after the last `test_clk_en`.
- `err_count` and `error_flag` update on the clock edge that ends CHECK2.
- `sys_reset` mid-run: everything returns to reset values on the next edge; no further `test_clk_en`.

## Configuration
- `BIST_LOOP_EN` defined:
  - NEXT with no further enabled chain wraps to the lowest enabled chain and goes to LOAD, so the run continues until `stop`.
  - DONE is unreachable except through `chain_mask`=0.
  - `err_count` keeps accumulating across passes.
- Undefined: a run terminates in DONE after the highest enabled chain.

## Test plan
- Mask 6'b000101 with `PAT_LEN`=4, `tick` every cycle, `comparison_result`=0:
  - `K` shows 000001, then 000100.
  - 4 `test_clk_en` pulses per chain.
  - `done` 16 cycles after `start`; `err_count`=0.
- Mask 6'b111111 with `comparison_result`=1 always and `halt_on_err`=0: `err_count`=6, `error_flag`=1, `done`=1.
- `halt_on_err`=1 with a failure on chain 2:
  - Stays in HALT with `K`=000100 while `continua` is held high from before.
  - A 0→1 edge of `continua` advances to chain 3.
- `stop` asserted mid-SHIFT of chain 3 after 1 failure:
  - IDLE next cycle, `K`=0, `err_count`=1 retained.
  - A new `start` clears `err_count` to 0.
- `err_count` preloaded to saturation via `CNT_W`=2, 5 failing chains: `err_count` stays 3.
- With `BIST_LOOP_EN`, mask 6'b000011: `K` cycles 1, 2, 1, 2 with `done` never high; `stop` returns to IDLE.
